// File: rtl/adder_pipe_gen.sv
// adder_pipe_gen: pipelined N-bit add/subtract unit with valid/ready handshake.
//   The carry chain is cut into STAGES registered ripple chunks of CHUNK bits.
//   Operands, partial sums and the chunk carry travel together down the pipe,
//   so one operation completes per clock with a fixed latency of STAGES.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   operand handshake (a, b, ci, sub)
//   a, b [N-1:0]        operands
//   ci                  carry in (add only)
//   sub                 0: a+b+ci, 1: a-b
//   out_valid/out_ready result handshake
//   sum [N:0]           result; sum[N] = carry out (sub: 1 = no borrow)
//   ovf                 signed overflow of sum[N-1:0]

// One pipeline stage: ripples chunk K and registers everything for stage K+1.
module adder_pipe_stage #(
  parameter int N     = 16,
  parameter int CHUNK = 4,
  parameter int K     = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         i_vld,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [N-1:0] i_s,
  input  logic         i_c,
  output logic         o_vld,
  output logic [N-1:0] o_a,
  output logic [N-1:0] o_b,
  output logic [N-1:0] o_s,
  output logic         o_c
);
  localparam int LO = K * CHUNK;

  logic [CHUNK:0]   w_cy;
  logic [CHUNK-1:0] w_sum;
  logic [N-1:0]     w_s;

  assign w_cy[0] = i_c;

  for (genvar j = 0; j < CHUNK; j++) begin : g_fa
    logic w_p;
    assign w_p       = i_a[LO+j] ^ i_b[LO+j];
    assign w_sum[j]  = w_p ^ w_cy[j];
    assign w_cy[j+1] = (i_a[LO+j] & i_b[LO+j]) | (w_cy[j] & w_p);
  end

  // Low chunks already computed pass through; this chunk is filled in.
  always_comb begin
    w_s            = i_s;
    w_s[LO+:CHUNK] = w_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vld <= 1'b0;
      o_a   <= '0;
      o_b   <= '0;
      o_s   <= '0;
      o_c   <= 1'b0;
    end else if (en) begin
      o_vld <= i_vld;
      o_a   <= i_a;
      o_b   <= i_b;
      o_s   <= w_s;
      o_c   <= w_cy[CHUNK];
    end
  end
endmodule

module adder_pipe_gen #(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   sum,
  output logic         ovf
);
  localparam int CHUNK = N / STAGES;

  if (N % STAGES != 0) begin : g_bad_cfg
    $error("adder_pipe_gen: N must be a multiple of STAGES");
  end

  // Index 0 is the combinational stage-0 input; index k+1 is stage k's register.
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][N-1:0] w_a, w_b, w_s;
  logic [STAGES:0]        w_c;
  logic                   w_en;
  logic                   w_unused;

  // Whole pipe advances together; a stalled output freezes every stage.
  assign w_en     = ~vld_pipe[STAGES] | out_ready;
  assign in_ready = w_en;

  // Subtract is a + ~b + 1: invert b and force the initial carry.
  assign vld_pipe[0] = in_valid;
  assign w_a[0]      = a;
  assign w_b[0]      = sub ? ~b : b;
  assign w_s[0]      = '0;
  assign w_c[0]      = sub | ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_pipe_stage #(.N(N), .CHUNK(CHUNK), .K(k)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (w_en),
      .i_vld (vld_pipe[k]),
      .i_a   (w_a[k]),
      .i_b   (w_b[k]),
      .i_s   (w_s[k]),
      .i_c   (w_c[k]),
      .o_vld (vld_pipe[k+1]),
      .o_a   (w_a[k+1]),
      .o_b   (w_b[k+1]),
      .o_s   (w_s[k+1]),
      .o_c   (w_c[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign sum       = {w_c[STAGES], w_s[STAGES]};
  // Only the sign bits of the final operands feed the overflow test.
  assign ovf       = (w_a[STAGES][N-1] == w_b[STAGES][N-1]) &
                     (w_s[STAGES][N-1] != w_a[STAGES][N-1]);
  assign w_unused  = ^{w_a[STAGES], w_b[STAGES]};
endmodule

// File: tb/tb_adder_pipe_gen.sv
module tb_adder_pipe_gen;
  localparam int N = 16;
  localparam int STAGES = 4;

  typedef struct {
    logic [N:0] s;
    logic       o;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, ci, sub, out_valid, out_ready, ovf;
  logic [N-1:0] a, b;
  logic [N:0]   sum;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rnd_rdy = 0;

  adder_pipe_gen #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: unsigned/signed integer arithmetic, no bit-level adder.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic c, input logic s);
    exp_t e;
    int   sv;
    int   uv;
    if (s) begin
      uv = int'(x) - int'(y);
      e.s = {(x >= y), uv[N-1:0]};
      sv = int'($signed(x)) - int'($signed(y));
    end else begin
      uv = int'(x) + int'(y) + int'(c);
      e.s = uv[N:0];
      sv = int'($signed(x)) + int'($signed(y)) + int'(c);
    end
    e.o = (sv > 32767) || (sv < -32768);
    return e;
  endfunction

  function automatic logic [N-1:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic cyc();
    @(negedge clk);
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one operand set and hold it until accepted.
  task automatic xfer(input logic [N-1:0] ta, input logic [N-1:0] tb,
                      input logic tci, input logic tsub, output bit ok);
    int g = 0;
    cyc();
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
    #1;
    while (!in_ready && g < 100) begin
      cyc();
      #1;
      g++;
    end
    ok = in_ready;
    if (!ok) chk("accept_timeout", 32'(g), 32'd0);
  endtask

  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb,
                      input logic tci, input logic tsub);
    bit ok;
    xfer(ta, tb, tci, tsub, ok);
    if (ok) q.push_back(model(ta, tb, tci, tsub));
  endtask

  task automatic send_k(input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input logic tci, input logic tsub,
                        input logic [N:0] es, input logic eo);
    bit   ok;
    exp_t e;
    xfer(ta, tb, tci, tsub, ok);
    e.s = es;
    e.o = eo;
    if (ok) q.push_back(e);
  endtask

  // Called right after an accepted op on an empty pipe.
  task automatic lat(input string nm);
    int c = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      c++;
    end while (!out_valid && c < 20);
    chk(nm, 32'(c), 32'(STAGES));
  endtask

  task automatic drain(input string nm);
    int g = 0;
    while ((q.size() != 0 || out_valid) && g < 300) begin
      cyc();
      in_valid = 1'b0;
      #1;
      g++;
    end
    chk(nm, 32'(q.size()), 32'd0);
  endtask

  // Monitor: every result handed over is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'(sum), 32'h0);
        end else begin
          e = q.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("ovf", 32'(ovf), 32'(e.o));
        end
      end
    end
  end

  initial begin
    logic [N:0] hold;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed values
    send_k(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0);
    lat("latency_first");
    send_k(16'h0FFF, 16'h0001, 1'b0, 1'b0, 17'h01000, 1'b0);
    send_k(16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00001, 1'b0);
    send_k(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0);
    send_k(16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002, 1'b0);
    send_k(16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1);
    send_k(16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1);
    drain("drain_directed");

    // Stream of 8, then a 3-cycle output stall
    for (int i = 0; i < 8; i++)
      send(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    hold = sum;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum_stable", 32'(sum), 32'(hold));
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain("drain_stream");

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++)
      send(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    send_k(16'h0FFF, 16'h0001, 1'b0, 1'b0, 17'h01000, 1'b0);
    lat("latency_after_reset");
    drain("drain_reset");

    // Randomized traffic with random backpressure and input bubbles
    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cyc();
        in_valid = 1'b0;
        a = 16'($urandom);
      end else begin
        send(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
      end
    end
    drain("drain_random");
    rnd_rdy = 0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
